// File: rtl/alu_arb_pkg.sv
// Shared core definitions for the EXU ALU sequencer: datapath widths, ALU opcodes
// and the alu_arb FSM encodings.
package alu_arb_pkg;

  localparam int CPU_WIDTH    = 32;
  localparam int ALU_OP_WIDTH = 4;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 4'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 4'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 4'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 4'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 4'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 4'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = 4'd8;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 4'd9;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_EQU  = 4'd10;

  // Exposed as plain constants so debug tooling can decode the state register.
  localparam logic [1:0] ALU_ARB_IDLE = 2'd0;
  localparam logic [1:0] ALU_ARB_EXEC = 2'd1;
  localparam logic [1:0] ALU_ARB_RESP = 2'd2;

  typedef enum logic [1:0] {
    ARB_IDLE = ALU_ARB_IDLE,
    ARB_EXEC = ALU_ARB_EXEC,
    ARB_RESP = ALU_ARB_RESP
  } arb_state_e;

  typedef struct packed {
    logic [ALU_OP_WIDTH-1:0] op;
    logic [CPU_WIDTH-1:0]    src1;
    logic [CPU_WIDTH-1:0]    src2;
  } alu_cmd_t;

endpackage

// File: rtl/alu_arb_rr_arb2.sv
// Two-input round-robin pick: a lone requester always wins, and on contention the
// requester that did not win last time is chosen.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    if (valid == 2'b11) begin
      grant = !last;
    end else begin
      grant = valid[1];
    end
  end

endmodule

// File: rtl/alu_arb.sv
// Round-robin sequencer for the shared EXU ALU: grants one of two requesters,
// drives registered operands, captures the result and returns it with a tag.
import alu_arb_pkg::*;

module alu_arb #(
  parameter int TAG_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [ALU_OP_WIDTH-1:0] req0_op,
  input  logic [CPU_WIDTH-1:0]    req0_src1,
  input  logic [CPU_WIDTH-1:0]    req0_src2,
  input  logic [TAG_W-1:0]        req0_tag,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic [ALU_OP_WIDTH-1:0] req1_op,
  input  logic [CPU_WIDTH-1:0]    req1_src1,
  input  logic [CPU_WIDTH-1:0]    req1_src2,
  input  logic [TAG_W-1:0]        req1_tag,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic [CPU_WIDTH-1:0]    alu_src1,
  output logic [CPU_WIDTH-1:0]    alu_src2,
  input  logic [CPU_WIDTH-1:0]    alu_res,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_id,
  output logic [TAG_W-1:0]        rsp_tag,
  output logic [CPU_WIDTH-1:0]    rsp_data
);

  arb_state_e       state;
  arb_state_e       state_next;
  logic             last_grant;
  logic             grant;
  logic             accept;
  logic             capture;
  logic             rsp_done;
  alu_cmd_t         win_cmd;
  logic [TAG_W-1:0] win_tag;

  rr_arb2 u_rr_arb2 (
    .valid ({req1_valid, req0_valid}),
    .last  (last_grant),
    .grant (grant)
  );

  always_comb begin
    win_cmd = '0;
    win_tag = '0;
    if (grant) begin
      win_cmd.op   = req1_op;
      win_cmd.src1 = req1_src1;
      win_cmd.src2 = req1_src2;
      win_tag      = req1_tag;
    end else begin
      win_cmd.op   = req0_op;
      win_cmd.src1 = req0_src1;
      win_cmd.src2 = req0_src2;
      win_tag      = req0_tag;
    end
  end

  // With enable low or reset asserted nothing may advance, so every strobe stays low.
  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    rsp_done   = 1'b0;
    if (enable && !rst) begin
      case (state)
        ARB_IDLE: begin
          req0_ready = req0_valid && !grant;
          req1_ready = req1_valid && grant;
          accept     = req0_ready || req1_ready;
          if (accept) begin
            state_next = ARB_EXEC;
          end
        end
        ARB_EXEC: begin
          capture    = 1'b1;
          state_next = ARB_RESP;
        end
        ARB_RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_done   = 1'b1;
            state_next = ARB_IDLE;
          end
        end
        default: state_next = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // last_grant resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      alu_op     <= '0;
      alu_src1   <= '0;
      alu_src2   <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_tag    <= '0;
      rsp_data   <= '0;
    end else begin
      if (accept) begin
        alu_op     <= win_cmd.op;
        alu_src1   <= win_cmd.src1;
        alu_src2   <= win_cmd.src2;
        rsp_tag    <= win_tag;
        rsp_id     <= grant;
        last_grant <= grant;
      end
      if (capture) begin
        rsp_data  <= alu_res;
        rsp_valid <= 1'b1;
      end
      if (rsp_done) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arb.sv
// Scoreboard bench for alu_arb: directed vectors push expected responses, a
// negedge monitor pops and compares each accepted response.
module tb_alu_arb;
  import alu_arb_pkg::*;

  localparam int TAG_W = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    enable;
  logic                    req0_valid, req1_valid;
  logic                    req0_ready, req1_ready;
  logic [ALU_OP_WIDTH-1:0] req0_op, req1_op;
  logic [CPU_WIDTH-1:0]    req0_src1, req0_src2, req1_src1, req1_src2;
  logic [TAG_W-1:0]        req0_tag, req1_tag;
  logic [ALU_OP_WIDTH-1:0] alu_op;
  logic [CPU_WIDTH-1:0]    alu_src1, alu_src2, alu_res;
  logic                    rsp_valid, rsp_ready, rsp_id;
  logic [TAG_W-1:0]        rsp_tag;
  logic [CPU_WIDTH-1:0]    rsp_data;

  typedef struct {
    logic                 id;
    logic [TAG_W-1:0]     tag;
    logic [CPU_WIDTH-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  logic [ALU_OP_WIDTH-1:0] op_list [11] = '{ALU_AND, ALU_OR, ALU_XOR, ALU_ADD, ALU_SUB,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_EQU};

  always #5 clk = ~clk;

  alu_arb #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_tag(req1_tag),
    .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_res(alu_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_tag(rsp_tag), .rsp_data(rsp_data)
  );

  function automatic logic [CPU_WIDTH-1:0] ref_alu(input logic [ALU_OP_WIDTH-1:0] op,
                                                   input logic [CPU_WIDTH-1:0] a,
                                                   input logic [CPU_WIDTH-1:0] b);
    logic [CPU_WIDTH-1:0] r;
    r = '0;
    case (op)
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $signed(a) >>> b[4:0];
      ALU_SLT:  r = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: r = {31'd0, a < b};
      ALU_EQU:  r = {31'd0, a == b};
      default:  r = '0;
    endcase
    return r;
  endfunction

  // The parent's combinational ALU sitting on the operand bus.
  always_comb alu_res = ref_alu(alu_op, alu_src1, alu_src2);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && enable && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
        checkOutput("rsp_tag", {28'd0, rsp_tag}, {28'd0, e.tag});
        checkOutput("rsp_data", rsp_data, e.data);
      end
    end
  end

  task automatic doCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic id, input logic [TAG_W-1:0] tag, input logic [31:0] data);
    exp_t e;
    e.id = id;
    e.tag = tag;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic id, input logic [ALU_OP_WIDTH-1:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [TAG_W-1:0] tag);
    if (id) begin
      req1_op = op; req1_src1 = a; req1_src2 = b; req1_tag = tag; req1_valid = 1'b1;
    end else begin
      req0_op = op; req0_src1 = a; req0_src2 = b; req0_tag = tag; req0_valid = 1'b1;
    end
  endtask

  task automatic waitRsp(input string name);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      doCycle();
      n++;
    end
    checkOutput(name, {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic loadSoak(input logic id);
    applyStimulus(id, op_list[$urandom_range(0, 10)], $urandom, $urandom,
                  TAG_W'($urandom_range(0, 15)));
  endtask

  task automatic runSoak();
    int   done_cnt, given0, given1, cycles;
    logic prev_g, g, exp_g;
    bit   have_prev, granted;
    done_cnt = 0; cycles = 0; have_prev = 0; prev_g = 1'b0;
    loadSoak(1'b0); loadSoak(1'b1);
    given0 = 1; given1 = 1;
    while (done_cnt < 20 && cycles < 2000) begin
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      granted = 0;
      g = 1'b0;
      if (req0_ready && req1_ready) checkOutput("soak_dual_ready", 32'd1, 32'd0);
      if (req0_ready || req1_ready) begin
        g = req1_ready;
        if (have_prev) begin
          exp_g = !prev_g;
          checkOutput("soak_alternate", {31'd0, g}, {31'd0, exp_g});
        end
        if (g) pushExp(1'b1, req1_tag, ref_alu(req1_op, req1_src1, req1_src2));
        else   pushExp(1'b0, req0_tag, ref_alu(req0_op, req0_src1, req0_src2));
        prev_g = g; have_prev = 1; granted = 1; done_cnt++;
      end
      @(posedge clk);
      #1;
      cycles++;
      if (granted) begin
        if (g) begin
          if (given1 < 10) begin loadSoak(1'b1); given1++; end
          else req1_valid = 1'b0;
        end else begin
          if (given0 < 10) begin loadSoak(1'b0); given0++; end
          else req0_valid = 1'b0;
        end
      end
    end
    checkOutput("soak_grants", done_cnt, 32'd20);
    rsp_ready = 1'b1;
    cycles = 0;
    while (sb.size() != 0 && cycles < 50) begin
      doCycle();
      cycles++;
    end
    checkOutput("soak_drained", sb.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; enable = 1'b1; rsp_ready = 1'b1;
    applyStimulus(1'b0, ALU_ADD, 32'd1, 32'd2, 4'h1);
    applyStimulus(1'b1, ALU_ADD, 32'd3, 32'd4, 4'h2);
    #1;
    checkOutput("reset_req0_ready", {31'd0, req0_ready}, 32'd0);
    checkOutput("reset_req1_ready", {31'd0, req1_ready}, 32'd0);
    doCycle(); doCycle();
    checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("reset_rsp_data", rsp_data, 32'd0);
    checkOutput("reset_alu_op", {28'd0, alu_op}, 32'd0);
    checkOutput("reset_alu_src1", alu_src1, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b0;
    doCycle();

    // Single request: ready in T, operands in T+1, response in T+2.
    applyStimulus(1'b0, ALU_ADD, 32'h5, 32'h3, 4'hA);
    #1;
    checkOutput("single_ready", {31'd0, req0_ready}, 32'd1);
    pushExp(1'b0, 4'hA, 32'h8);
    doCycle();
    req0_valid = 1'b0;
    checkOutput("single_alu_op", {28'd0, alu_op}, {28'd0, ALU_ADD});
    checkOutput("single_alu_src1", alu_src1, 32'h5);
    checkOutput("single_alu_src2", alu_src2, 32'h3);
    checkOutput("single_no_early_rsp", {31'd0, rsp_valid}, 32'd0);
    doCycle();
    checkOutput("single_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    doCycle();

    // Reset during EXEC drops the operation without a response.
    applyStimulus(1'b0, ALU_OR, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'h3);
    #1;
    checkOutput("rstmid_ready", {31'd0, req0_ready}, 32'd1);
    doCycle();
    req0_valid = 1'b0;
    checkOutput("rstmid_alu_src1", alu_src1, 32'hFFFF_0000);
    rst = 1'b1;
    doCycle();
    rst = 1'b0;
    checkOutput("rstmid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rstmid_alu_op", {28'd0, alu_op}, 32'd0);
    checkOutput("rstmid_alu_src2", alu_src2, 32'd0);
    checkOutput("rstmid_rsp_tag", {28'd0, rsp_tag}, 32'd0);
    checkOutput("rstmid_rsp_data", rsp_data, 32'd0);
    for (int i = 0; i < 3; i++) begin
      doCycle();
      checkOutput("rstmid_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end

    // Contention after reset: requester 0 first, requester 1 three cycles later.
    applyStimulus(1'b0, ALU_SUB, 32'd10, 32'd4, 4'h1);
    applyStimulus(1'b1, ALU_XOR, 32'hF0, 32'h0F, 4'h2);
    #1;
    checkOutput("cont_req0_ready", {31'd0, req0_ready}, 32'd1);
    checkOutput("cont_req1_ready", {31'd0, req1_ready}, 32'd0);
    pushExp(1'b0, 4'h1, 32'd6);
    doCycle();
    req0_valid = 1'b0;
    n = 1;
    while (!req1_ready && n < 20) begin
      doCycle();
      n++;
    end
    checkOutput("cont_req1_gap", n, 32'd3);
    pushExp(1'b1, 4'h2, 32'hFF);
    doCycle();
    req1_valid = 1'b0;
    waitRsp("cont_req1_rsp");
    doCycle();

    // Back-pressure: response held stable and no grants while stalled.
    rsp_ready = 1'b0;
    applyStimulus(1'b0, ALU_SLL, 32'h1, 32'h4, 4'h5);
    #1;
    checkOutput("bp_ready", {31'd0, req0_ready}, 32'd1);
    pushExp(1'b0, 4'h5, 32'h10);
    doCycle();
    req0_valid = 1'b0;
    applyStimulus(1'b1, ALU_SRA, 32'h8000_0000, 32'h4, 4'h6);
    waitRsp("bp_rsp");
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("bp_data", rsp_data, 32'h10);
      checkOutput("bp_tag", {28'd0, rsp_tag}, 32'h5);
      checkOutput("bp_id", {31'd0, rsp_id}, 32'd0);
      checkOutput("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
      checkOutput("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
      doCycle();
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("bp_no_bypass", {31'd0, req1_ready}, 32'd0);
    doCycle();
    checkOutput("bp_next_accept", {31'd0, req1_ready}, 32'd1);
    pushExp(1'b1, 4'h6, 32'hF800_0000);
    doCycle();
    req1_valid = 1'b0;
    waitRsp("bp_req1_rsp");
    doCycle();

    // Enable low during EXEC freezes the block; response follows re-enable.
    applyStimulus(1'b0, ALU_SLT, 32'hFFFF_FFFF, 32'h1, 4'h7);
    #1;
    checkOutput("en_ready", {31'd0, req0_ready}, 32'd1);
    pushExp(1'b0, 4'h7, 32'h1);
    doCycle();
    req0_valid = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      doCycle();
      checkOutput("en_hold", {31'd0, rsp_valid}, 32'd0);
    end
    enable = 1'b1;
    doCycle();
    checkOutput("en_resume", {31'd0, rsp_valid}, 32'd1);
    doCycle();

    // A response handshake with enable low must not retire the response.
    rsp_ready = 1'b0;
    applyStimulus(1'b1, ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 4'h8);
    #1;
    checkOutput("en2_ready", {31'd0, req1_ready}, 32'd1);
    pushExp(1'b1, 4'h8, 32'h0);
    doCycle();
    req1_valid = 1'b0;
    waitRsp("en2_rsp");
    enable = 1'b0;
    rsp_ready = 1'b1;
    applyStimulus(1'b0, ALU_EQU, 32'h1234, 32'h1234, 4'h9);
    for (int i = 0; i < 2; i++) begin
      doCycle();
      checkOutput("en_ignored_hs", {31'd0, rsp_valid}, 32'd1);
      checkOutput("en_ready_forced", {31'd0, req0_ready}, 32'd0);
    end
    enable = 1'b1;
    #1;
    checkOutput("en2_no_bypass", {31'd0, req0_ready}, 32'd0);
    doCycle();
    checkOutput("en2_next_accept", {31'd0, req0_ready}, 32'd1);
    pushExp(1'b0, 4'h9, 32'h1);
    doCycle();
    req0_valid = 1'b0;
    waitRsp("en2_req0_rsp");
    doCycle();

    runSoak();

    repeat (3) doCycle();
    checkOutput("final_sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
